// File: rtl/sw4_debounce_pkg.sv
// Shared types and default parameters for the switch-bank debouncer.
// Contents:
//   db_state_t    FSM state encoding (IDLE, COUNT)
//   SW_WIDTH      default number of switch bits
//   SW_DB_CYCLES  default number of consecutive stable cycles before commit
package sw_db_pkg;

  typedef enum logic {IDLE, COUNT} db_state_t;

  localparam int SW_WIDTH     = 4;
  localparam int SW_DB_CYCLES = 16;

endpackage

// File: rtl/sw4_debounce_if.sv
// Switch-bank interface between the raw switches, the debouncer and its consumer.
// Optional macro: SW4_EDGE_EN adds the per-bit sw_rise/sw_fall pulses.
// Signals:
//   sw_in    raw switch levels, asynchronous to clk
//   sw_out   debounced word
//   sw_chg   one-cycle pulse when sw_out takes a new value
//   busy     high while a candidate word is being qualified
//   sw_rise  per-bit 0->1 pulse aligned with sw_chg   (SW4_EDGE_EN only)
//   sw_fall  per-bit 1->0 pulse aligned with sw_chg   (SW4_EDGE_EN only)
// Modports: master = switch source / consumer side, slave = debouncer.
interface sw4_debounce_if #(
  parameter int WIDTH = sw_db_pkg::SW_WIDTH
);
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic             sw_chg;
  logic             busy;
`ifdef SW4_EDGE_EN
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;

  modport master (output sw_in, input sw_out, sw_chg, busy, sw_rise, sw_fall);
  modport slave  (input sw_in, output sw_out, sw_chg, busy, sw_rise, sw_fall);
`else
  modport master (output sw_in, input sw_out, sw_chg, busy);
  modport slave  (input sw_in, output sw_out, sw_chg, busy);
`endif
endinterface

// File: rtl/sw4_debounce_sync2.sv
// Two-flop synchroniser, one chain per bit.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset, clears both stages
//   d      asynchronous input word
//   q      synchronised word, two clk edges after sampling
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sw4_debounce.sv
// Word-wide switch debouncer in front of the 4-bit reduction-gate block.
// The synchronised word must stay identical for DB_CYCLES consecutive cycles
// before it is committed to sw_out; any movement restarts or aborts qualification.
// Optional macro: SW4_EDGE_EN adds registered per-bit rise/fall pulses on commit.
// Ports:
//   clk    clock, all flops rise-edge
//   rst_n  asynchronous active-low reset
//   bus    sw4_debounce_if slave: sw_in in; sw_out, sw_chg, busy (, sw_rise, sw_fall) out
//
// state | meaning
// IDLE  | synchronised word equals sw_out, nothing to qualify
// COUNT | candidate word differs from sw_out, counting stable cycles
module sw4_debounce
  import sw_db_pkg::*;
#(
  parameter int WIDTH     = SW_WIDTH,
  parameter int DB_CYCLES = SW_DB_CYCLES
) (
  input logic          clk,
  input logic          rst_n,
  sw4_debounce_if.slave bus
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync_w;

  db_state_t        state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sw_out_q, sw_out_d;
  logic             chg_q, chg_d;

  sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.sw_in),
    .q     (sync_w)
  );

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    sw_out_d = sw_out_q;
    chg_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_w != sw_out_q) begin
          cand_d  = sync_w;
          cnt_d   = CNT_ONE;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // Order matters: a bounce back to sw_out wins over a restart.
        if (sync_w == sw_out_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (sync_w != cand_q) begin
          cand_d = sync_w;
          cnt_d  = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          sw_out_d = cand_q;
          chg_d    = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      sw_out_q <= '0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      sw_out_q <= sw_out_d;
      chg_q    <= chg_d;
    end
  end

  assign bus.sw_out = sw_out_q;
  assign bus.sw_chg = chg_q;
  assign bus.busy   = (state_q == COUNT);

`ifdef SW4_EDGE_EN
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Edges are taken against the word being replaced, only on the commit cycle.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    if (chg_d) begin
      rise_d = cand_q & ~sw_out_q;
      fall_d = ~cand_q & sw_out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.sw_rise = rise_q;
  assign bus.sw_fall = fall_q;
`endif

endmodule

// File: tb/tb_sw4_debounce.sv
// Directed bench for sw4_debounce with DB_CYCLES=4 (commit 5 edges after sampling).
// Inputs change 1 time unit after a rising edge; that next rising edge is edge 0.
// After the k-th call of tick following a change, outputs reflect edge k-1.
module tb_sw4_debounce;

  localparam int W  = 4;
  localparam int DB = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  sw4_debounce_if #(.WIDTH(W)) bus ();

  sw4_debounce #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [W-1:0] v);
    bus.sw_in = v;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    int nchg;
    rst_n     = 1'b0;
    bus.sw_in = 4'b1010;
    #3;
    checks++;
    if (bus.sw_out !== 4'b0000) $display("FAIL reset_sw_out got=%b exp=0000", bus.sw_out);
    else passes++;
    checks++;
    if (bus.sw_chg !== 1'b0) $display("FAIL reset_sw_chg got=%b exp=0", bus.sw_chg);
    else passes++;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy);
    else passes++;
    repeat (3) tick();
    rst_n = 1'b1;
    nchg  = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.sw_chg === 1'b1) nchg++;
      checks++;
      if (bus.sw_out !== ((i >= 5) ? 4'b1010 : 4'b0000))
        $display("FAIL release_sw_out edge=%0d got=%b exp=%b", i, bus.sw_out,
                 (i >= 5) ? 4'b1010 : 4'b0000);
      else passes++;
      checks++;
      if (bus.sw_chg !== (i == 5))
        $display("FAIL release_sw_chg edge=%0d got=%b exp=%b", i, bus.sw_chg, (i == 5));
      else passes++;
    end
    checks++;
    if (nchg != 1) $display("FAIL release_chg_count got=%0d exp=1", nchg);
    else passes++;
  endtask

  task automatic test_step();
    settle(4'b0000);
    bus.sw_in = 4'b0110;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.busy !== (i >= 2 && i <= 4))
        $display("FAIL step_busy edge=%0d got=%b exp=%b", i, bus.busy, (i >= 2 && i <= 4));
      else passes++;
      checks++;
      if (bus.sw_out !== ((i >= 5) ? 4'b0110 : 4'b0000))
        $display("FAIL step_sw_out edge=%0d got=%b exp=%b", i, bus.sw_out,
                 (i >= 5) ? 4'b0110 : 4'b0000);
      else passes++;
      checks++;
      if (bus.sw_chg !== (i == 5))
        $display("FAIL step_sw_chg edge=%0d got=%b exp=%b", i, bus.sw_chg, (i == 5));
      else passes++;
    end
  endtask

  task automatic test_toggle();
    int nchg;
    settle(4'b0000);
    nchg = 0;
    for (int i = 0; i < 20; i++) begin
      bus.sw_in = (((i / 2) % 2) == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (bus.sw_chg === 1'b1) nchg++;
    end
    bus.sw_in = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 5 && bus.sw_chg === 1'b1) nchg++;
      checks++;
      if (bus.sw_chg !== (i == 5))
        $display("FAIL toggle_final_chg edge=%0d got=%b exp=%b", i, bus.sw_chg, (i == 5));
      else passes++;
    end
    checks++;
    if (nchg != 0) $display("FAIL toggle_spurious_chg got=%0d exp=0", nchg);
    else passes++;
    checks++;
    if (bus.sw_out !== 4'b0001) $display("FAIL toggle_sw_out got=%b exp=0001", bus.sw_out);
    else passes++;
  endtask

  task automatic test_glitch();
    int nchg;
    int nbusy;
    int nout;
    settle(4'b0000);
    nchg  = 0;
    nbusy = 0;
    nout  = 0;
    bus.sw_in = 4'b1000;
    tick();
    bus.sw_in = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.sw_chg === 1'b1) nchg++;
      if (bus.busy === 1'b1) nbusy++;
      if (bus.sw_out !== 4'b0000) nout++;
    end
    checks++;
    if (nbusy == 0) $display("FAIL glitch_busy_seen got=%0d exp>0", nbusy);
    else passes++;
    checks++;
    if (nchg != 0) $display("FAIL glitch_chg got=%0d exp=0", nchg);
    else passes++;
    checks++;
    if (nout != 0) $display("FAIL glitch_sw_out_nonzero got=%0d exp=0", nout);
    else passes++;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL glitch_idle got=%b exp=0", bus.busy);
    else passes++;
  endtask

  task automatic test_restart();
    int nchg;
    int nbad;
    int chg_at;
    settle(4'b0000);
    nchg   = 0;
    nbad   = 0;
    chg_at = -1;
    bus.sw_in = 4'b0001;
    repeat (3) tick();
    bus.sw_in = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.sw_out === 4'b0001) nbad++;
      if (bus.sw_chg === 1'b1) begin
        nchg++;
        chg_at = i;
      end
    end
    checks++;
    if (nbad != 0) $display("FAIL restart_intermediate got=%0d exp=0", nbad);
    else passes++;
    checks++;
    if (nchg != 1) $display("FAIL restart_chg_count got=%0d exp=1", nchg);
    else passes++;
    checks++;
    if (chg_at != 5) $display("FAIL restart_chg_edge got=%0d exp=5", chg_at);
    else passes++;
    checks++;
    if (bus.sw_out !== 4'b0011) $display("FAIL restart_sw_out got=%b exp=0011", bus.sw_out);
    else passes++;
  endtask

  task automatic test_reset_mid_count();
    int nchg;
    int nout;
    settle(4'b0000);
    settle(4'b0011);
    bus.sw_in = 4'b1111;
    repeat (4) tick();
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL abort_pre_busy got=%b exp=1", bus.busy);
    else passes++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sw_out !== 4'b0000) $display("FAIL abort_sw_out got=%b exp=0000", bus.sw_out);
    else passes++;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", bus.busy);
    else passes++;
    checks++;
    if (bus.sw_chg !== 1'b0) $display("FAIL abort_sw_chg got=%b exp=0", bus.sw_chg);
    else passes++;
    bus.sw_in = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;
    nchg = 0;
    nout = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.sw_chg === 1'b1) nchg++;
      if (bus.sw_out !== 4'b0000) nout++;
    end
    checks++;
    if (nchg != 0) $display("FAIL abort_post_chg got=%0d exp=0", nchg);
    else passes++;
    checks++;
    if (nout != 0) $display("FAIL abort_post_sw_out got=%0d exp=0", nout);
    else passes++;
  endtask

`ifdef SW4_EDGE_EN
  task automatic test_edges();
    settle(4'b0110);
    bus.sw_in = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.sw_rise !== ((i == 5) ? 4'b0001 : 4'b0000))
        $display("FAIL edge_rise edge=%0d got=%b exp=%b", i, bus.sw_rise,
                 (i == 5) ? 4'b0001 : 4'b0000);
      else passes++;
      checks++;
      if (bus.sw_fall !== ((i == 5) ? 4'b0100 : 4'b0000))
        $display("FAIL edge_fall edge=%0d got=%b exp=%b", i, bus.sw_fall,
                 (i == 5) ? 4'b0100 : 4'b0000);
      else passes++;
    end
  endtask
`endif

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_step();
    test_toggle();
    test_glitch();
    test_restart();
    test_reset_mid_count();
`ifdef SW4_EDGE_EN
    test_edges();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
